// File: rtl/sram_arbiter.sv
// rtl/sram_arbiter.sv - two-port (CPU/video) SRAM access arbiter with per-access timeout
// One access in flight at a time: IDLE grants, ISSUE waits for m_ack or timeout, DONE pulses ACK.
module sram_arbiter #(
  parameter int AW       = 20,
  parameter int DW       = 48,
  parameter int TIMEOUT  = 255,
  parameter int VID_PRIO = 0
) (
  input  logic          clk_50mhz,
  input  logic          rst,
  input  logic          r_stb,
  input  logic          v_stb,
  input  logic          r_we,
  input  logic          v_we,
  input  logic [AW-1:0] r_addra,
  input  logic [AW-1:0] v_addra,
  input  logic [DW-1:0] r_dina,
  input  logic [DW-1:0] v_dina,
  output logic [DW-1:0] r_douta,
  output logic [DW-1:0] v_douta,
  output logic          r_ACK,
  output logic          v_ACK,
  output logic          r_ERR,
  output logic          v_ERR,
  output logic          m_stb,
  output logic          m_we,
  output logic [AW-1:0] m_addra,
  output logic [DW-1:0] m_dina,
  input  logic [DW-1:0] m_douta,
  input  logic          m_ack,
  output logic          busy
);

  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_DONE} state_t;

  localparam logic [7:0] TIMER_MAX = 8'(TIMEOUT);

  state_t     r_state;
  logic       r_gnt_vid;
  logic       r_last_vid;
  logic [7:0] r_timer;

  logic       w_any_stb;
  logic       w_pick_vid;
  logic [7:0] w_timer_inc;

  // Video takes a tie when prioritised, or when the CPU held the previous grant.
  assign w_any_stb   = r_stb | v_stb;
  assign w_pick_vid  = v_stb & (~r_stb | (VID_PRIO != 0) | ~r_last_vid);
  assign w_timer_inc = r_timer + 8'd1;

  always_ff @(posedge clk_50mhz) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_gnt_vid  <= 1'b0;
      r_last_vid <= 1'b1;
      r_timer    <= 8'd0;
      m_stb      <= 1'b0;
      m_we       <= 1'b0;
      m_addra    <= '0;
      m_dina     <= '0;
      r_douta    <= '0;
      v_douta    <= '0;
      r_ACK      <= 1'b0;
      v_ACK      <= 1'b0;
      r_ERR      <= 1'b0;
      v_ERR      <= 1'b0;
      busy       <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_any_stb) begin
            r_gnt_vid  <= w_pick_vid;
            r_last_vid <= w_pick_vid;
            m_we       <= w_pick_vid ? v_we    : r_we;
            m_addra    <= w_pick_vid ? v_addra : r_addra;
            m_dina     <= w_pick_vid ? v_dina  : r_dina;
            r_timer    <= 8'd0;
            m_stb      <= 1'b1;
            busy       <= 1'b1;
            r_state    <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          // An ack on the final allowed cycle still completes without error.
          if (m_ack) begin
            if (r_gnt_vid) v_douta <= m_douta;
            else           r_douta <= m_douta;
            m_stb   <= 1'b0;
            v_ACK   <= r_gnt_vid;
            r_ACK   <= ~r_gnt_vid;
            r_state <= ST_DONE;
          end else if (w_timer_inc == TIMER_MAX) begin
            r_timer <= w_timer_inc;
            m_stb   <= 1'b0;
            v_ACK   <= r_gnt_vid;
            r_ACK   <= ~r_gnt_vid;
            v_ERR   <= r_gnt_vid;
            r_ERR   <= ~r_gnt_vid;
            r_state <= ST_DONE;
          end else begin
            r_timer <= w_timer_inc;
          end
        end
        ST_DONE: begin
          r_ACK   <= 1'b0;
          v_ACK   <= 1'b0;
          r_ERR   <= 1'b0;
          v_ERR   <= 1'b0;
          busy    <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/sram_arbiter.md
SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 Parameter AW, default 20, address width in words.
REQ-002 Parameter DW, default 48, data width.
REQ-003 Parameter TIMEOUT, default 255, max cycles an issued access waits for m_ack; legal range 1..255.
REQ-004 Parameter VID_PRIO, default 0; 1 = video port always wins, 0 = round-robin.
REQ-005 clk_50mhz  in  1  sole clock; all state changes on rising edge.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 r_stb, v_stb  in  1 each  CPU / video request strobe, held until ack.
REQ-008 r_we, v_we  in  1 each  write enable, valid while strobe high.
REQ-009 r_addra, v_addra  in  AW each  word address.
REQ-010 r_dina, v_dina  in  DW each  write data.
REQ-011 r_douta, v_douta  out  DW each  registered read data.
REQ-012 r_ACK, v_ACK  out  1 each  one-cycle completion pulse.
REQ-013 r_ERR, v_ERR  out  1 each  one-cycle pulse, coincident with ACK, on timeout.
REQ-014 m_stb, m_we  out  1 each  request to SRAM core.
REQ-015 m_addra  out  AW; m_dina  out  DW  registered downstream address/data.
REQ-016 m_douta  in  DW; m_ack  in  1  downstream read data / completion.
REQ-017 busy  out  1  high in any state but IDLE.

Function
REQ-018 FSM states IDLE, ISSUE, DONE; encoding free.
REQ-019 IDLE: no strobe -> stay; else grant one port, latch its we/addra/dina into m_we/m_addra/m_dina, clear timer, go ISSUE.
REQ-020 Grant, VID_PRIO=0: one strobe -> that port; both -> port not granted last (last_grant resets to video, so CPU wins first tie).
REQ-021 Grant, VID_PRIO=1: video wins any tie; last_grant still updated.
REQ-022 ISSUE: m_stb=1, m_we/m_addra/m_dina held constant; requester inputs ignored until return to IDLE.
REQ-023 ISSUE, m_ack=1: capture m_douta into granted port's douta (reads and writes both), go DONE.
REQ-024 ISSUE, timer reaches TIMEOUT without m_ack: go DONE with error flag set; douta unchanged.
REQ-025 Timer is 8 bits, counts ISSUE cycles; never wraps (saturates at TIMEOUT).
REQ-026 DONE: m_stb=0, ACK of granted port =1 for exactly this cycle, ERR=1 if error flag; next state IDLE unconditionally.
REQ-027 Minimum latency: strobe sampled at edge N, m_stb high N+1, m_ack sampled high at N+1 -> ACK high N+2; idle cycle N+3 before next grant.
REQ-028 Non-granted port's ACK/ERR/douta never change during another port's transaction.
REQ-029 m_ack outside ISSUE ignored.
REQ-030 Strobe dropped during ISSUE: transaction still completes; ACK still pulses.
REQ-031 At most one of r_ACK, v_ACK high in any cycle.

Reset
REQ-032 rst has priority over every transition, incl. mid-transaction; next edge -> IDLE.
REQ-033 Reset values: m_stb=0, m_we=0, m_addra=0, m_dina=0, r_douta=v_douta=0, all ACK/ERR=0, busy=0, timer=0, last_grant=video, error flag=0.
REQ-034 Transaction in progress at reset discarded; no ACK issued for it.

Verification
REQ-035 CPU read addr 0x00010, m_ack 2 cycles after m_stb with m_douta=0x0000_1234_5678 -> r_douta=0x000012345678, r_ACK one cycle, v_ACK=0.
REQ-036 VID_PRIO=0, both strobes same edge after reset, m_ack immediate -> CPU served first, video second; a further tie goes to CPU.
REQ-037 VID_PRIO=1, both strobes continuously -> only v_ACK ever pulses; r_ACK=0.
REQ-038 TIMEOUT=4, video write, m_ack never -> m_stb high exactly 4 cycles, then v_ACK=v_ERR=1 one cycle, v_douta unchanged.
REQ-039 rst asserted during ISSUE -> next cycle m_stb=0, busy=0, no ACK; new CPU request afterwards completes normally.
REQ-040 CPU write addr 0x80000 data 0xABCD_0000_0001, v_addra/v_dina toggled during ISSUE -> m_addra/m_dina stay 0x80000 / 0xABCD00000001 until DONE.
